// File: rtl/jkff_counter_pkg.sv
// rtl/jkff_counter_pkg.sv - JK encodings and load clamp helper shared by the JK counters
//
// Contents:
//   JK_HOLD / JK_RESET / JK_SET / JK_TOGGLE  {J,K} control encodings for jk_ff_cell
//   clamp_to_mod(value, modulus)             limits a load value to modulus-1
package jkff_counter_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Values at or above the modulus would leave the counter outside its
    // range, so they are pinned to the top of the range instead.
    function automatic logic [15:0] clamp_to_mod(input logic [15:0] value,
                                                 input int unsigned modulus);
        if (32'(value) >= modulus)
            return 16'(modulus - 1);
        else
            return value;
    endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// rtl/jk_ff_cell.sv - single JK flip-flop with synchronous active-low reset
//
// Parameters:
//   RESET_VAL  value taken by q when reset is low at a rising clk edge
// Ports:
//   clk    clock, rising edge
//   reset  synchronous active-low reset
//   j, k   JK controls: 00 hold, 01 clear, 10 set, 11 toggle
//   q      registered output
module jk_ff_cell
    import jkff_counter_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= RESET_VAL;
        end else begin
            case ({j, k})
                JK_HOLD:   q <= q;
                JK_RESET:  q <= 1'b0;
                JK_SET:    q <= 1'b1;
                default:   q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jkff_downcounter.sv
// rtl/jkff_downcounter.sv - modulo-N down counter built from per-bit JK flip-flop cells
//
// Parameters:
//   WIDTH    counter width in bits (1..16)
//   MODULUS  count modulus, 2..2**WIDTH; q runs MODULUS-1 down to 0
// Ports:
//   clk       clock, rising edge
//   reset     synchronous active-low reset, q <= MODULUS-1
//   en        count enable, decrement once per cycle
//   load      parallel load strobe, overrides en
//   load_val  value loaded (clamped to MODULUS-1)
//   q         current count
//   zero      q == 0
//   tc        en & zero: wrap happens on this edge
// Build option:
//   JKFF_DOWNCOUNTER_SATURATE_EN  when defined, an enabled count at 0 holds at 0
module jkff_downcounter
    import jkff_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0]      load_d;
    logic [WIDTH-1:0]      low_zero;
    logic [WIDTH-1:0][1:0] jk;

    assign load_d = WIDTH'(clamp_to_mod(16'(load_val), MODULUS));
    assign zero   = (q == '0);
    assign tc     = en & zero;

    // low_zero[i] is the borrow into bit i: every bit below i is zero, so a
    // decrement must flip bit i.
    always_comb begin
        logic acc;
        acc      = 1'b1;
        low_zero = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            low_zero[i] = acc;
            acc         = acc & ~q[i];
        end
    end

    // Reset is applied inside each cell, so only load/en/hold are decoded here.
    always_comb begin
        jk = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (load) begin
                jk[i] = load_d[i] ? JK_SET : JK_RESET;
            end else if (en) begin
                if (zero) begin
`ifdef JKFF_DOWNCOUNTER_SATURATE_EN
                    jk[i] = JK_HOLD;
`else
                    jk[i] = MAX_VAL[i] ? JK_SET : JK_RESET;
`endif
                end else begin
                    jk[i] = low_zero[i] ? JK_TOGGLE : JK_HOLD;
                end
            end else begin
                jk[i] = JK_HOLD;
            end
        end
    end

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
        jk_ff_cell #(
            .RESET_VAL (MAX_VAL[g])
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (jk[g][1]),
            .k     (jk[g][0]),
            .q     (q[g])
        );
    end

endmodule

// File: tb/tb_jkff_downcounter.sv
// tb/tb_jkff_downcounter.sv - scoreboard bench for jkff_downcounter, modulus 16 and 10
module tb_jkff_downcounter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       ld  = 1'b0;
    logic [3:0] lv  = '0;

    logic [3:0] q16, q10;
    logic       zero16, zero10, tc16, tc10;

    int n_cmp = 0;
    int n_err = 0;

    int exp16_q[$];
    int exp10_q[$];
    int m16 = 0;
    int m10 = 0;
    bit valid = 1'b0;

`ifdef JKFF_DOWNCOUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    always #5 clk = ~clk;

    jkff_downcounter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk (clk), .reset (rst), .en (en), .load (ld), .load_val (lv),
        .q (q16), .zero (zero16), .tc (tc16)
    );

    jkff_downcounter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk (clk), .reset (rst), .en (en), .load (ld), .load_val (lv),
        .q (q10), .zero (zero10), .tc (tc10)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model(input int cur, input bit r, input bit l,
                                 input int v, input bit e, input int md);
        if (!r)     return md - 1;
        if (l)      return (v > md - 1) ? md - 1 : v;
        if (!e)     return cur;
        if (cur == 0) return SAT ? 0 : md - 1;
        return cur - 1;
    endfunction

    // Drive one cycle: check the combinational flags against the model,
    // queue the expected post-edge counts, then pop and compare after the edge.
    task automatic step(input bit r, input bit e, input bit l, input logic [3:0] v);
        int n16, n10;
        rst = r; en = e; ld = l; lv = v;
        #1;
        if (valid) begin
            check("zero16", zero16, m16 == 0);
            check("tc16",   tc16,   e && (m16 == 0));
            check("zero10", zero10, m10 == 0);
            check("tc10",   tc10,   e && (m10 == 0));
        end
        if (valid || !r) begin
            n16 = model(m16, r, l, int'(v), e, 16);
            n10 = model(m10, r, l, int'(v), e, 10);
            exp16_q.push_back(n16);
            exp10_q.push_back(n10);
            m16 = n16;
            m10 = n10;
            valid = 1'b1;
        end
        @(posedge clk);
        #1;
        if (exp16_q.size() > 0) check("q16_model", q16, exp16_q.pop_front());
        if (exp10_q.size() > 0) check("q10_model", q10, exp10_q.pop_front());
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    initial begin
        @(posedge clk);
        #1;

        // T1: reset and idle hold
        do_reset();
        check("t1_q16", q16, 15);
        check("t1_zero16", zero16, 0);
        check("t1_tc16", tc16, 0);
        check("t1_q10", q10, 9);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
        check("t1_hold16", q16, 15);

        // T2: 17 enabled edges through the wrap
        for (int i = 0; i < 17; i++) step(1, 1, 0, 0);
        check("t2_q16", q16, SAT ? 0 : 14);
        check("t2_q10", q10, SAT ? 0 : 2);

        // T3: load overrides en, counting resumes from the loaded value
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
        check("t3_q16_7", q16, 7);
        step(1, 1, 1, 4'd9);
        check("t3_load16", q16, 9);
        check("t3_load10", q10, 9);
        step(1, 1, 0, 0);
        check("t3_dec8", q16, 8);
        step(1, 1, 0, 0);
        check("t3_dec7", q16, 7);

        // T4: modulus 10 wrap and load clamp
        do_reset();
        for (int i = 0; i < 9; i++) step(1, 1, 0, 0);
        check("t4_q10_0", q10, 0);
        check("t4_zero10", zero10, 1);
        step(1, 1, 0, 0);
        check("t4_wrap10", q10, SAT ? 0 : 9);
        step(1, 0, 1, 4'd12);
        check("t4_clamp10", q10, 9);
        check("t4_load16", q16, 12);

        // T5: reset beats load and en
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
        check("t5_q16_5", q16, 5);
        step(0, 1, 1, 4'd3);
        check("t5_rst16", q16, 15);
        step(1, 1, 0, 0);
        check("t5_resume16", q16, 14);

        // T6: saturation at zero
        if (SAT) begin
            do_reset();
            for (int i = 0; i < 13; i++) step(1, 1, 0, 0);
            check("t6_q2", q16, 2);
            step(1, 1, 0, 0);
            check("t6_q1", q16, 1);
            step(1, 1, 0, 0);
            check("t6_q0", q16, 0);
            for (int i = 0; i < 2; i++) begin
                step(1, 1, 0, 0);
                check("t6_hold0", q16, 0);
            end
            en = 1'b1; ld = 1'b0; #1;
            check("t6_tc_at0", tc16, 1);
            step(1, 0, 1, 4'd4);
            check("t6_load4", q16, 4);
        end

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) >= 5,
                 $urandom_range(0, 99) < 65,
                 $urandom_range(0, 99) < 10,
                 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
